// File: rtl/param_step_counter.sv
// rtl/param_step_counter.sv - modulo-N up/down step counter with clear, load, wrap/saturate
// and terminal-count / wrap-pulse outputs for the multiplier step sequencer.
module param_step_counter #(
   parameter int WIDTH    = 2,
   parameter int MODULUS  = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count_out,
   output logic             at_max,
   output logic             at_zero,
   output logic             tc,
   output logic             wrap_pulse
);

   generate
      if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
         $error("param_step_counter: WIDTH must be in 1..16");
      end
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("param_step_counter: MODULUS must be in 2..2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   assign count_out  = count_q;
   assign wrap_pulse = wrap_q;
   assign at_max     = (count_q == MAX_C);
   assign at_zero    = (count_q == '0);
   assign tc         = en & ((up_dn & at_max) | (~up_dn & at_zero));

   always_comb begin
      count_d = count_q;
      wrap_d  = tc;
      if (sclr) begin
         count_d = '0;
         wrap_d  = 1'b0;
      end else if (load) begin
         // Out-of-range loads clamp so the count can never leave 0..MODULUS-1.
         count_d = (load_val > MAX_C) ? MAX_C : load_val;
         wrap_d  = 1'b0;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) count_d = SATURATE ? count_q : '0;
            else        count_d = count_q + 1'b1;
         end else begin
            if (at_zero) count_d = SATURATE ? count_q : MAX_C;
            else         count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

endmodule

// File: tb/tb_param_step_counter.sv
// tb/tb_param_step_counter.sv - bench for param_step_counter: three parameterisations
// driven in parallel, checked every cycle against an arithmetic model plus literal vectors.
module tb_param_step_counter;

   localparam int W_A[3] = '{2, 3, 2};
   localparam int M_A[3] = '{4, 5, 4};
   localparam int S_A[3] = '{0, 0, 1};

   logic        clk = 1'b0;
   logic        aclr_n = 1'b0;
   logic        sclr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1;
   logic [15:0] lv = '0;
   bit          run_chk = 1'b0;

   logic [1:0] c0;
   logic [2:0] c1;
   logic [1:0] c2;
   logic       am[3], az[3], tcv[3], wp[3];

   int n_chk = 0;
   int n_err = 0;
   int mc[3];
   bit mw[3];

   always #5 clk = ~clk;

   param_step_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) u_w2m4 (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .load(load), .load_val(lv[1:0]),
      .en(en), .up_dn(up_dn), .count_out(c0), .at_max(am[0]), .at_zero(az[0]),
      .tc(tcv[0]), .wrap_pulse(wp[0]));

   param_step_counter #(.WIDTH(3), .MODULUS(5), .SATURATE(1'b0)) u_w3m5 (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .load(load), .load_val(lv[2:0]),
      .en(en), .up_dn(up_dn), .count_out(c1), .at_max(am[1]), .at_zero(az[1]),
      .tc(tcv[1]), .wrap_pulse(wp[1]));

   param_step_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b1)) u_w2m4s (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .load(load), .load_val(lv[1:0]),
      .en(en), .up_dn(up_dn), .count_out(c2), .at_max(am[2]), .at_zero(az[2]),
      .tc(tcv[2]), .wrap_pulse(wp[2]));

   function automatic int dc(input int i);
      case (i)
         0:       return int'(c0);
         1:       return int'(c1);
         default: return int'(c2);
      endcase
   endfunction

   function automatic bit mtc(input int i);
      return en && ((up_dn && mc[i] == M_A[i] - 1) || (!up_dn && mc[i] == 0));
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: plain modular / clamped arithmetic on integers.
   always @(posedge clk or negedge aclr_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!aclr_n) begin
            mc[i] = 0;
            mw[i] = 1'b0;
         end else if (sclr) begin
            mc[i] = 0;
            mw[i] = 1'b0;
         end else if (load) begin
            int v;
            v = int'(lv) % (1 << W_A[i]);
            mc[i] = (v > M_A[i] - 1) ? M_A[i] - 1 : v;
            mw[i] = 1'b0;
         end else begin
            mw[i] = mtc(i);
            if (en) begin
               if (up_dn) mc[i] = S_A[i] != 0 ? ((mc[i] + 1 > M_A[i] - 1) ? M_A[i] - 1 : mc[i] + 1)
                                              : (mc[i] + 1) % M_A[i];
               else       mc[i] = S_A[i] != 0 ? ((mc[i] == 0) ? 0 : mc[i] - 1)
                                              : (mc[i] + M_A[i] - 1) % M_A[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("inst%0d count", i), dc(i), mc[i]);
            check($sformatf("inst%0d at_max", i), am[i], mc[i] == M_A[i] - 1);
            check($sformatf("inst%0d at_zero", i), az[i], mc[i] == 0);
            check($sformatf("inst%0d tc", i), tcv[i], mtc(i));
            check($sformatf("inst%0d wrap_pulse", i), wp[i], mw[i]);
         end
      end
   end

   task automatic drive(input logic s, input logic l, input logic [15:0] v,
                        input logic e, input logic u);
      sclr = s; load = l; lv = v; en = e; up_dn = u;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int exp_up[12];
      int n_wrap;
      exp_up = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};

      drive(0, 0, 0, 0, 1);
      run_chk = 1'b1;
      tick();
      tick();
      check("reset count", c0, 0);
      check("reset at_zero", az[0], 1);
      check("reset at_max", am[0], 0);
      check("reset wrap", wp[0], 0);
      check("reset tc en0", tcv[0], 0);
      drive(0, 0, 0, 1, 0);
      #1 check("reset tc en1 down", tcv[0], 1);

      // reset mid-count
      drive(0, 0, 0, 1, 1);
      aclr_n = 1'b1;
      tick();
      tick();
      check("pre-abort count", c0, 2);
      #1 aclr_n = 1'b0;
      #1 check("async clear count", c0, 0);
      check("async clear wrap", wp[0], 0);
      check("async clear inst1 count", c1, 0);
      #2 aclr_n = 1'b1;
      check("after release count", c0, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("restart step %0d", k), c0, k % 4);
         check($sformatf("restart tc %0d", k), tcv[0], k == 3);
         check($sformatf("restart wrap %0d", k), wp[0], k == 4);
      end

      // non-power-of-two modulus
      drive(1, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 1, 1);
      n_wrap = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         check($sformatf("mod5 step %0d", k), c1, exp_up[k]);
         check($sformatf("mod5 range %0d", k), c1 < 5, 1);
         if (wp[1]) n_wrap++;
      end
      check("mod5 wrap count", n_wrap, 2);

      // down wrap
      drive(1, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("down step %0d", k), c0, (4 - (k % 4)) % 4);
      end

      // down saturate from 1
      drive(0, 1, 1, 0, 0);
      tick();
      check("sat load", c2, 1);
      drive(0, 0, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("sat count %0d", k), c2, 0);
         check($sformatf("sat wrap %0d", k), wp[2], k >= 2);
      end

      // load clamp and priority
      drive(0, 1, 7, 0, 1);
      tick();
      check("load clamp mod5", c1, 4);
      check("load clamp mod4", c0, 3);
      drive(1, 1, 2, 1, 1);
      tick();
      check("priority count", c1, 0);
      check("priority wrap", wp[1], 0);

      // enable gating
      drive(0, 0, 0, 1, 1); tick(); check("gate 1", c0, 1);
      drive(0, 0, 0, 0, 1); tick(); check("gate 2", c0, 1);
      tick();                       check("gate 3", c0, 1);
      drive(0, 0, 0, 1, 1); tick(); check("gate 4", c0, 2);
      drive(0, 1, 3, 0, 1);
      tick();
      #1 check("tc gated at max", tcv[0], 0);
      check("at_max held", am[0], 1);

      // direction flip at terminal value
      drive(0, 0, 0, 1, 1);
      #1 check("tc at max up", tcv[0], 1);
      drive(0, 0, 0, 1, 0);
      #1 check("tc at max down", tcv[0], 0);
      tick();
      check("flip count", c0, 2);
      check("flip wrap", wp[0], 0);

      drive(0, 0, 0, 0, 1);
      tick();
      tick();
      run_chk = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/param_step_counter.md
Name: param_step_counter

Overview:
Parametrised modulo-N step counter for the sequential multiplier datapath and its control FSMs. It generalises the fixed 2-bit step counter. It adds configurable width and modulus, up/down direction, enable, synchronous clear, parallel load, and a wrap-or-saturate mode. It also produces terminal-count and wrap indications so the controller can detect the last partial-product step without extra decode logic.

Parameters:
WIDTH, 2, bit width of count_out; legal range 1..16.
MODULUS, 4, count range is 0..MODULUS-1; legal range 2..2**WIDTH; illegal values are a compile-time error via generate-time check.
SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
clk  input  1  rising-edge clock
aclr_n  input  1  asynchronous active-low reset; clears all state immediately
sclr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load of load_val
load_val  input  WIDTH  value to load
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
count_out  output  WIDTH  registered count value
at_max  output  1  combinational, count_out == MODULUS-1
at_zero  output  1  combinational, count_out == 0
tc  output  1  combinational, en & ((up_dn & at_max) | (~up_dn & at_zero))
wrap_pulse  output  1  registered, one-cycle pulse after a terminal step

Behaviour:
- One clock. Reset is asynchronous and active-low: aclr_n low forces count_out=0 and wrap_pulse=0 immediately, without waiting for a clock edge. Release is synchronous to clk.
- Outputs while reset is asserted: count_out=0, wrap_pulse=0, at_zero=1, at_max=0, tc=en&~up_dn.
- Priority at each rising edge, highest first: sclr, then load, then en, then hold.
  - sclr=1: count_out<=0; wrap_pulse<=0.
  - load=1: count_out<=min(load_val, MODULUS-1). Out-of-range values clamp to MODULUS-1. wrap_pulse<=0.
  - en=1, up_dn=1, not at_max: count_out<=count_out+1.
  - en=1, up_dn=1, at_max: count_out<=0 if SATURATE=0, otherwise hold.
  - en=1, up_dn=0, not at_zero: count_out<=count_out-1.
  - en=1, up_dn=0, at_zero: count_out<=MODULUS-1 if SATURATE=0, otherwise hold.
  - en=0: count_out holds.
- wrap_pulse<=tc on every edge where neither sclr nor load is active. It is high for exactly one cycle after a terminal step, in both wrap and saturate modes. In saturate mode it stays high on consecutive cycles while en keeps stepping against the limit.
- Latency: count_out updates one cycle after the qualifying edge. tc has zero latency and is valid in the same cycle as the terminal step. wrap_pulse follows tc by one cycle.
- No arithmetic overflow into bits above WIDTH. Non-power-of-two MODULUS never reaches values ≥ MODULUS, except transiently under no condition.
- Direction change mid-count takes effect on the next enabled edge. There is no pipeline to flush.
- aclr_n asserted mid-count aborts the count: no wrap_pulse is emitted, and counting restarts from 0 after release.

Test Plan:
- Reset mid-count: WIDTH=2, MODULUS=4. Count to 2, pulse aclr_n low for 3 ns between edges -> count_out=0 before the next edge. Release with en=1 -> 0,1,2,3,0. tc=1 while count=3; wrap_pulse=1 in the cycle count shows 0.
- Non-power-of-two: WIDTH=3, MODULUS=5, up. 12 enabled edges -> sequence 1,2,3,4,0,1,2,3,4,0,1,2. count_out never ≥5. Two wrap_pulses.
- Down wrap and saturate:
  - MODULUS=4, SATURATE=0, up_dn=0 from 0 -> 3,2,1,0,3.
  - SATURATE=1, from 1 -> 0,0,0 with wrap_pulse high on the 2nd and 3rd cycles.
- Load clamp and priority:
  - WIDTH=3, MODULUS=5, load_val=7, load=1 -> count_out=4.
  - sclr=1, load=1, en=1 together -> count_out=0, wrap_pulse=0.
- Enable gating: en toggled 1,0,0,1 from 0 -> 1,1,1,2. tc=0 whenever en=0, even at the terminal value.
- Direction flip at the terminal value: count=3, up_dn switched to 0 with en=1 -> 2, no wrap_pulse.
